// File: rtl/router_register.sv
// router_register
// Datapath register block of a 1-to-3 packet router. It latches the header
// byte and streams header and payload bytes towards the selected output
// FIFO. A byte that arrives while that FIFO is full is parked and replayed
// later. It also accumulates even (XOR) parity over header and payload,
// captures the received parity byte, and flags a mismatch.
//
// The router FSM drives the one-hot state strobes. If strobes ever overlap,
// each register resolves the overlap with its own fixed priority order.
// Reset is asynchronous and active-low, and it discards every piece of
// packet state.

module router_register (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] din,
    input  logic       fifo_full,
    input  logic       detect_addr,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       lfd_state,
    input  logic       rst_int_reg,
    output logic [7:0] dout,
    output logic       err,
    output logic       parity_done,
    output logic       low_pkt_valid
);

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [7:0] header_reg;      // last accepted header byte
    logic [7:0] full_byte_reg;   // byte parked while the FIFO was full
    logic [7:0] int_parity_reg;  // running XOR of header and payload
    logic [7:0] pkt_parity_reg;  // parity byte received with the packet

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    // Address 2'b11 does not exist in a 1-to-3 router. Such a header is ignored.
    logic header_load;
    // LOAD_DATA with room in the FIFO: the byte on din goes straight out.
    logic load_live;
    // LOAD_DATA with the FIFO full: the byte on din must be parked.
    logic load_blocked;
    // The parity byte arrives directly (pkt_valid already low, FIFO has room).
    logic parity_from_din;
    // The parity byte was parked earlier and is replayed in LOAD_AFTER_FULL.
    logic parity_from_hold;
    // Header and payload bytes that contribute to the running parity.
    logic accum_header;
    logic accum_payload;

    assign header_load      = detect_addr & pkt_valid & (din[1:0] != 2'b11);
    assign load_live        = ld_state & ~fifo_full;
    assign load_blocked     = ld_state & fifo_full;
    assign parity_from_din  = load_live & ~pkt_valid;
    assign parity_from_hold = laf_state & low_pkt_valid & ~parity_done;
    assign accum_header     = lfd_state & pkt_valid;
    assign accum_payload    = ld_state & pkt_valid & ~full_state;

    // Latch the header byte only when its destination address is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            header_reg <= 8'h00;
        end else if (header_load) begin
            header_reg <= din;
        end
    end

    // Output byte selection.
    // Header first, then live payload, then hold while the FIFO is full,
    // then replay of the parked byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 8'h00;
        end else if (lfd_state) begin
            dout <= header_reg;
        end else if (load_live) begin
            dout <= din;
        end else if (load_blocked) begin
            dout <= dout;
        end else if (laf_state) begin
            dout <= full_byte_reg;
        end
    end

    // Park the incoming byte when the FIFO cannot accept it.
    // LOAD_FIRST_DATA outranks LOAD_DATA, as it does on dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_byte_reg <= 8'h00;
        end else if (!lfd_state && load_blocked) begin
            full_byte_reg <= din;
        end
    end

    // Running parity. The header is counted once, in LOAD_FIRST_DATA.
    // Payload bytes are counted while pkt_valid is high.
    // The parity byte itself never enters this register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_parity_reg <= 8'h00;
        end else if (detect_addr) begin
            int_parity_reg <= 8'h00;
        end else if (accum_header) begin
            int_parity_reg <= int_parity_reg ^ header_reg;
        end else if (accum_payload) begin
            int_parity_reg <= int_parity_reg ^ din;
        end
    end

    // Capture the received parity byte, either direct or replayed from the
    // parked-byte register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_parity_reg <= 8'h00;
        end else if (detect_addr) begin
            pkt_parity_reg <= 8'h00;
        end else if (parity_from_din) begin
            pkt_parity_reg <= din;
        end else if (parity_from_hold) begin
            pkt_parity_reg <= full_byte_reg;
        end
    end

    // Sticky flag: the parity byte has been received for this packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_done <= 1'b0;
        end else if (detect_addr) begin
            parity_done <= 1'b0;
        end else if (parity_from_din || parity_from_hold) begin
            parity_done <= 1'b1;
        end
    end

    // Records that pkt_valid dropped while loading data.
    // The FSM clears it explicitly with rst_int_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // Parity compare. The result is valid one cycle after parity_done rises,
    // and it is re-evaluated while parity_done stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (detect_addr) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_parity_reg != pkt_parity_reg);
        end
    end

endmodule

// File: tb/tb_router_register.sv
// tb_router_register
// Directed bench for router_register. Each stimulus task describes one
// router event (header, first data, payload byte, parity byte, FIFO full,
// replay, ...). It updates a packet-level model of what the block must
// present afterwards. A compare process checks all outputs against that
// model on every falling clock edge. A few hand-computed literals pin the
// model itself.

module tb_router_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] din;
    logic       fifo_full;
    logic       detect_addr;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       err;
    logic       parity_done;
    logic       low_pkt_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    router_register dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .din           (din),
        .fifo_full     (fifo_full),
        .detect_addr   (detect_addr),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .lfd_state     (lfd_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .err           (err),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid)
    );

    // Packet-level model: the accepted header, the parked byte, the XOR of
    // all counted bytes, the received parity byte, and the visible outputs.
    logic [7:0] m_hdr, m_held, m_xor, m_par, m_dout;
    logic       m_pd, m_err, m_lpv;
    // Expected outputs, committed just after each rising edge.
    logic [7:0] e_dout;
    logic       e_err, e_pd, e_lpv;
    bit         chk_en = 1'b0;

    logic [7:0] payload [8];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check8("dout", dout, e_dout);
            check1("err", err, e_err);
            check1("parity_done", parity_done, e_pd);
            check1("low_pkt_valid", low_pkt_valid, e_lpv);
        end
    end

    task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                         input logic fs, input logic rir, input logic pv, input logic ff,
                         input logic [7:0] d);
        detect_addr = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
        full_state = fs; rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; din = d;
    endtask

    // While a parity byte is held, the error flag reflects the compare of
    // the accumulated parity against that byte (using pre-edge values).
    task automatic parity_compare();
        if (m_pd) m_err = (m_xor != m_par);
    endtask

    task automatic model_zero();
        m_hdr = 8'h00; m_held = 8'h00; m_xor = 8'h00; m_par = 8'h00; m_dout = 8'h00;
        m_pd = 1'b0; m_err = 1'b0; m_lpv = 1'b0;
        e_dout = 8'h00; e_err = 1'b0; e_pd = 1'b0; e_lpv = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e_dout = m_dout; e_err = m_err; e_pd = m_pd; e_lpv = m_lpv;
    endtask

    //                          da lfd ld laf fs rir pv ff din
    task automatic do_header(input logic [7:0] b);
        drive(1, 0, 0, 0, 0, 0, 1, 0, b);
        if (b[1:0] != 2'b11) m_hdr = b;
        m_xor = 8'h00; m_par = 8'h00; m_pd = 1'b0; m_err = 1'b0;
        tick();
        $display("header   din=%h -> dout=%h pd=%b err=%b", b, dout, parity_done, err);
    endtask

    task automatic do_first();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hC3);
        parity_compare();
        m_dout = m_hdr; m_xor = m_xor ^ m_hdr;
        tick();
        $display("first    -> dout=%h", dout);
    endtask

    task automatic do_byte(input logic [7:0] b);
        drive(0, 0, 1, 0, 0, 0, 1, 0, b);
        parity_compare();
        m_dout = b; m_xor = m_xor ^ b;
        tick();
        $display("payload  din=%h -> dout=%h", b, dout);
    endtask

    task automatic do_parity(input logic [7:0] b);
        drive(0, 0, 1, 0, 0, 0, 0, 0, b);
        parity_compare();
        m_dout = b; m_par = b; m_pd = 1'b1; m_lpv = 1'b1;
        tick();
        $display("parity   din=%h -> dout=%h pd=%b lpv=%b", b, dout, parity_done, low_pkt_valid);
    endtask

    task automatic do_byte_full(input logic [7:0] b, input logic pv);
        drive(0, 0, 1, 0, 0, 0, pv, 1, b);
        parity_compare();
        m_held = b;
        if (pv) m_xor = m_xor ^ b;
        else    m_lpv = 1'b1;
        tick();
        $display("ld_full  din=%h pv=%b -> dout=%h lpv=%b", b, pv, dout, low_pkt_valid);
    endtask

    task automatic do_full();
        drive(0, 0, 0, 0, 1, 0, 1, 1, 8'h33);
        parity_compare();
        tick();
        $display("full     -> dout=%h", dout);
    endtask

    task automatic do_after_full();
        drive(0, 0, 0, 1, 0, 0, 1, 0, 8'h66);
        parity_compare();
        m_dout = m_held;
        if (m_lpv && !m_pd) begin
            m_pd = 1'b1;
            m_par = m_held;
        end
        tick();
        $display("laf      -> dout=%h pd=%b", dout, parity_done);
    endtask

    task automatic do_idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h5F);
        parity_compare();
        tick();
        $display("idle     -> pd=%b err=%b", parity_done, err);
    endtask

    task automatic do_clear();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        parity_compare();
        m_lpv = 1'b0;
        tick();
        $display("clear    -> lpv=%b", low_pkt_valid);
    endtask

    // Async reset asserted between clock edges; outputs must clear at once.
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check8({tag, "_dout"}, dout, 8'h00);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_pd"}, parity_done, 1'b0);
        check1({tag, "_lpv"}, low_pkt_valid, 1'b0);
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b1;
        $display("reset %s -> dout=%h err=%b pd=%b lpv=%b", tag, dout, err, parity_done, low_pkt_valid);
    endtask

    initial begin
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        payload[4] = 8'h55; payload[5] = 8'h66; payload[6] = 8'h77; payload[7] = 8'h88;

        // Power-on: arbitrary inputs, then a real falling edge on rst.
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 0, 1, 1, 8'h15);
        #1;
        rst = 1'b0;
        #1;
        check8("por_dout", dout, 8'h00);
        check1("por_err", err, 1'b0);
        check1("por_pd", parity_done, 1'b0);
        check1("por_lpv", low_pkt_valid, 1'b0);
        model_zero();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Good packet: header 15, 8 payload bytes, correct parity.
        do_header(8'h15);
        do_first();
        check8("good_hdr_lit", dout, 8'h15);
        for (int i = 0; i < 8; i++) do_byte(payload[i]);
        check8("good_xor_lit", m_xor, 8'h9D);
        do_parity(8'h9D);
        check1("good_pd_lit", parity_done, 1'b1);
        check1("good_lpv_lit", low_pkt_valid, 1'b1);
        do_idle();
        check1("good_err_lit", err, 1'b0);
        do_clear();
        check1("clear_lpv_lit", low_pkt_valid, 1'b0);

        // Bad parity: same packet, parity byte 46 decimal.
        do_header(8'h15);
        check1("hdr_clr_pd_lit", parity_done, 1'b0);
        do_first();
        for (int i = 0; i < 8; i++) do_byte(payload[i]);
        do_parity(8'd46);
        do_idle();
        check1("bad_err_lit", err, 1'b1);
        do_clear();

        // FIFO full: one payload byte parked, then the parity byte parked.
        do_header(8'h16);
        do_first();
        do_byte(8'h3C);
        do_byte_full(8'h5A, 1'b1);
        check8("full_hold_lit", dout, 8'h3C);
        do_full();
        do_after_full();
        check8("laf_data_lit", dout, 8'h5A);
        check1("laf_data_pd_lit", parity_done, 1'b0);
        do_byte_full(8'hAA, 1'b0);
        do_full();
        do_after_full();
        check8("laf_par_lit", dout, 8'hAA);
        check1("laf_par_pd_lit", parity_done, 1'b1);
        check8("laf_pkt_parity_lit", dut.pkt_parity_reg, 8'hAA);
        check8("full_xor_lit", m_xor, 8'h70);
        do_idle();
        check1("full_err_lit", err, 1'b1);
        do_clear();

        // Invalid address 3: the header is kept, and flags clear.
        do_header(8'h17);
        check1("inv_err_lit", err, 1'b0);
        check1("inv_pd_lit", parity_done, 1'b0);
        do_first();
        check8("inv_old_hdr_lit", dout, 8'h16);

        // Reset in the middle of a packet, then a clean packet.
        do_header(8'h21);
        do_first();
        do_byte(8'h7E);
        apply_reset("midrst");
        do_header(8'h21);
        do_first();
        do_byte(8'h7E);
        do_parity(8'h5F);
        do_idle();
        check1("post_rst_err_lit", err, 1'b0);
        do_clear();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
